// File: rtl/sample_pkg.sv
// Shared width, word type and signed-overflow helper for the sample adder block.
package sample_pkg;

  localparam int unsigned SAMPLE_WIDTH = 32;

  typedef logic [SAMPLE_WIDTH-1:0] word_t;

  // Two's-complement overflow: like-signed operands giving an opposite-signed result.
  function automatic logic ovf_f(input word_t a, input word_t b, input word_t s);
    return (a[SAMPLE_WIDTH-1] == b[SAMPLE_WIDTH-1]) && (s[SAMPLE_WIDTH-1] != a[SAMPLE_WIDTH-1]);
  endfunction

endpackage

// File: rtl/prefix_adder.sv
// Kogge-Stone parallel-prefix adder, carry-in fixed at zero.
module prefix_adder #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int unsigned LEVELS = $clog2(WIDTH);

  logic [WIDTH-1:0] w_g0;
  logic [WIDTH-1:0] w_p0;
  logic [WIDTH-1:0] w_gf;

  assign w_g0 = a & b;
  assign w_p0 = a ^ b;

  // Each level reads the previous level's group G/P through its generate scope;
  // group P is only built where a later level consumes it.
  for (genvar k = 0; k < LEVELS; k++) begin : g_lvl
    localparam int unsigned DIST = 1 << k;
    logic [WIDTH-1:0] w_gi;
    logic [WIDTH-1:0] w_pi;
    logic [WIDTH-1:0] w_go;

    if (k == 0) begin : g_first
      assign w_gi = w_g0;
      assign w_pi = w_p0;
    end else begin : g_next
      assign w_gi = g_lvl[k-1].w_go;
      assign w_pi = g_lvl[k-1].g_pnext.w_po;
    end

    assign w_go = w_gi | (w_pi & (w_gi << DIST));

    if (k < LEVELS - 1) begin : g_pnext
      localparam logic [WIDTH-1:0] LOWM = ~({WIDTH{1'b1}} << DIST);
      logic [WIDTH-1:0] w_po;
      assign w_po = w_pi & ((w_pi << DIST) | LOWM);
    end
  end

  assign w_gf = g_lvl[LEVELS-1].w_go;
  assign sum  = w_p0 ^ {w_gf[WIDTH-2:0], 1'b0};
  assign cout = w_gf[WIDTH-1];

endmodule

// File: rtl/sample.sv
// Combinational prefix adder with registered sum, carry, overflow and zero flags.
module sample
  import sample_pkg::*;
#(
  parameter int unsigned WIDTH = SAMPLE_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] z,
  output logic             cout,
  output logic [WIDTH-1:0] z_q,
  output logic             cout_q,
  output logic             ovf_q,
  output logic             zero_q
);

  logic [WIDTH-1:0] w_sum;
  logic             w_cout;
  logic             w_ovf;
  logic             w_zero;

  logic [WIDTH-1:0] r_z;
  logic             r_cout;
  logic             r_ovf;
  logic             r_zero;

  prefix_adder #(.WIDTH(WIDTH)) u_add (
    .a    (a),
    .b    (b),
    .sum  (w_sum),
    .cout (w_cout)
  );

  assign w_ovf  = ovf_f(a, b, w_sum);
  assign w_zero = (w_sum == '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_z    <= '0;
      r_cout <= 1'b0;
      r_ovf  <= 1'b0;
      r_zero <= 1'b1;
    end else begin
      r_z    <= w_sum;
      r_cout <= w_cout;
      r_ovf  <= w_ovf;
      r_zero <= w_zero;
    end
  end

  assign z      = w_sum;
  assign cout   = w_cout;
  assign z_q    = r_z;
  assign cout_q = r_cout;
  assign ovf_q  = r_ovf;
  assign zero_q = r_zero;

endmodule

// File: tb/tb_sample.sv
// Directed and random checks of sample against an arithmetic reference model.
module tb_sample;

  logic        clk;
  logic        reset;
  logic [31:0] a;
  logic [31:0] b;
  logic [31:0] z;
  logic        cout;
  logic [31:0] z_q;
  logic        cout_q;
  logic        ovf_q;
  logic        zero_q;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  sample #(.WIDTH(32)) dut (
    .clk    (clk),
    .reset  (reset),
    .a      (a),
    .b      (b),
    .z      (z),
    .cout   (cout),
    .z_q    (z_q),
    .cout_q (cout_q),
    .ovf_q  (ovf_q),
    .zero_q (zero_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: wide unsigned sum for z/cout, signed range test for overflow.
  function automatic void model(input logic [31:0] x, input logic [31:0] y,
                                output logic [31:0] s, output logic c,
                                output logic ov, output logic zr);
    logic [32:0] full;
    longint      ssum;
    full = {1'b0, x} + {1'b0, y};
    s    = full[31:0];
    c    = full[32];
    ssum = longint'($signed(x)) + longint'($signed(y));
    ov   = (ssum > 64'sd2147483647) || (ssum < -64'sd2147483648);
    zr   = (s == 32'd0);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_comb(input string tag);
    logic [31:0] s;
    logic c, ov, zr;
    model(a, b, s, c, ov, zr);
    chk({tag, ".z"}, z, s);
    chk({tag, ".cout"}, {31'd0, cout}, {31'd0, c});
  endtask

  task automatic chk_regs(input string tag, input logic [31:0] x, input logic [31:0] y);
    logic [31:0] s;
    logic c, ov, zr;
    model(x, y, s, c, ov, zr);
    chk({tag, ".z_q"}, z_q, s);
    chk({tag, ".cout_q"}, {31'd0, cout_q}, {31'd0, c});
    chk({tag, ".ovf_q"}, {31'd0, ovf_q}, {31'd0, ov});
    chk({tag, ".zero_q"}, {31'd0, zero_q}, {31'd0, zr});
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, ".z_q"}, z_q, 32'd0);
    chk({tag, ".cout_q"}, {31'd0, cout_q}, 32'd0);
    chk({tag, ".ovf_q"}, {31'd0, ovf_q}, 32'd0);
    chk({tag, ".zero_q"}, {31'd0, zero_q}, 32'd1);
  endtask

  // Apply just after a rising edge, check comb at the falling edge, regs after the next rise.
  task automatic vec(input string tag, input logic [31:0] x, input logic [31:0] y);
    @(posedge clk);
    #1;
    a = x;
    b = y;
    @(negedge clk);
    chk_comb(tag);
    @(posedge clk);
    #1;
    chk_regs(tag, x, y);
  endtask

  initial begin
    reset = 1'b1;
    a     = 32'd0;
    b     = 32'd0;
    #3;
    chk_reset_vals("rst_init");
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    vec("v1", 32'h12153524, 32'hC0895E81);
    chk("v1.exp_z", z_q, 32'hD29E93A5);
    vec("v2", 32'hFFFFFFFF, 32'h00000001);
    chk("v2.exp_zero", {31'd0, zero_q}, 32'd1);
    vec("v3", 32'h7FFFFFFF, 32'h00000001);
    chk("v3.exp_ovf", {31'd0, ovf_q}, 32'd1);
    vec("v4", 32'h80000000, 32'h80000000);
    chk("v4.exp_cout", {31'd0, cout_q}, 32'd1);

    // Mid-cycle reset with nonzero registered state.
    vec("v5", 32'hA5A5A5A5, 32'h0F0F0F0F);
    #2;
    reset = 1'b1;
    #1;
    chk_reset_vals("rst_async");
    chk_comb("rst_comb");
    a = 32'h00001234;
    b = 32'h00004321;
    #1;
    chk_comb("rst_comb2");
    @(posedge clk);
    #1;
    chk_reset_vals("rst_hold");
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 16; i++) begin
      @(posedge clk);
      #1;
      chk_regs("rnd_reg", a, b);
      a = $urandom;
      b = $urandom;
      if (i == 3) b = ~a + 32'd1;
      if (i == 7) b = ~a;
      @(negedge clk);
      chk_comb("rnd_comb");
    end
    @(posedge clk);
    #1;
    chk_regs("rnd_reg_last", a, b);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
